// File: rtl/rotary_event_scheduler.sv
// Rotary-encoder event scheduler: detent events are queued in a small FIFO and
// applied one per time slot to an LED pattern whose meaning depends on the mode.
module rotary_event_scheduler #(
  parameter int STEP_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rotation_event,
  input  logic       rotation_direction,
  input  logic       ROT_CENTER,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       overflow
);

  localparam int SLOT_W = $clog2(STEP_CYCLES);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_BAR    = 2'd2
  } mode_t;

  mode_t             mode_q, mode_d;
  logic              sync_1, sync_2;
  logic              db_level;
  logic [DB_W-1:0]   db_cnt;
  logic              advance_q;
  logic [SLOT_W-1:0] slot_cnt;
  logic [3:0]        fifo_dir;
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        fifo_count;
  logic [7:0]        led_q, led_d;
  logic [3:0]        bar_level, bar_level_d;
  logic              overflow_q;

  logic slot_edge, fifo_full, fifo_empty, push, pop, drop, push_ok, head_dir;

  function automatic logic [7:0] bar_pattern(input logic [3:0] lvl);
    logic [8:0] t;
    t = (9'd1 << lvl) - 9'd1;
    return t[7:0];
  endfunction

  // A pending mode advance suppresses both enqueue and service in its cycle.
  assign slot_edge  = (slot_cnt == SLOT_W'(STEP_CYCLES - 1));
  assign fifo_full  = (fifo_count == 3'd4);
  assign fifo_empty = (fifo_count == 3'd0);
  assign push       = rotation_event && !advance_q;
  assign pop        = slot_edge && !fifo_empty && !advance_q;
  assign drop       = push && fifo_full && !pop;
  assign push_ok    = push && !drop;
  assign head_dir   = fifo_dir[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      db_level  <= 1'b0;
      db_cnt    <= '0;
      advance_q <= 1'b0;
    end else begin
      sync_1    <= ROT_CENTER;
      sync_2    <= sync_1;
      advance_q <= 1'b0;
      if (sync_2 != db_level) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level  <= sync_2;
          db_cnt    <= '0;
          advance_q <= sync_2;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mode_q <= MODE_ROTATE;
    else     mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (advance_q) begin
      case (mode_q)
        MODE_ROTATE: mode_d = MODE_COUNT;
        MODE_COUNT:  mode_d = MODE_BAR;
        default:     mode_d = MODE_ROTATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || advance_q) begin
      slot_cnt <= '0;
    end else if (slot_edge) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  // When full, a simultaneous pop frees the head slot that the push overwrites.
  always_ff @(posedge clk) begin
    if (rst || advance_q) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push_ok) begin
        fifo_dir[wr_ptr] <= rotation_direction;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    led_d       = led_q;
    bar_level_d = bar_level;
    if (advance_q) begin
      bar_level_d = 4'd0;
      led_d       = (mode_d == MODE_ROTATE) ? 8'h01 : 8'h00;
    end else if (pop) begin
      case (mode_q)
        MODE_ROTATE: led_d = head_dir ? {led_q[6:0], led_q[7]} : {led_q[0], led_q[7:1]};
        MODE_COUNT:  led_d = head_dir ? led_q + 8'd1 : led_q - 8'd1;
        MODE_BAR: begin
          if (head_dir && bar_level != 4'd8)       bar_level_d = bar_level + 4'd1;
          else if (!head_dir && bar_level != 4'd0) bar_level_d = bar_level - 4'd1;
          led_d = bar_pattern(bar_level_d);
        end
        default: led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= 8'h01;
      bar_level  <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      bar_level <= bar_level_d;
      if (advance_q)  overflow_q <= 1'b0;
      else if (drop)  overflow_q <= 1'b1;
    end
  end

  assign led      = led_q;
  assign mode     = mode_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rotary_event_scheduler.sv
// Directed bench for rotary_event_scheduler: a default instance plus a
// long-slot instance used to fill the FIFO without an intervening slot edge.
module tb_rotary_event_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       rotation_event, rotation_direction, rot_center;
  logic [7:0] led;
  logic [1:0] mode;
  logic       overflow;
  logic       ev_l, dir_l, center_l;
  logic [7:0] led_l;
  logic [1:0] mode_l;
  logic       ov_l;

  int checks = 0;
  int errors = 0;
  int slot_pos = 0;

  rotary_event_scheduler #(.STEP_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .rotation_event(rotation_event),
    .rotation_direction(rotation_direction), .ROT_CENTER(rot_center),
    .led(led), .mode(mode), .overflow(overflow)
  );

  rotary_event_scheduler #(.STEP_CYCLES(16), .DEBOUNCE_CYCLES(8)) dut_long (
    .clk(clk), .rst(rst), .rotation_event(ev_l),
    .rotation_direction(dir_l), .ROT_CENTER(center_l),
    .led(led_l), .mode(mode_l), .overflow(ov_l)
  );

  always #5 clk = ~clk;

  task automatic next_cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      slot_pos = (slot_pos + 1) % 4;
    end
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic ev, input logic dir, input int n);
    rotation_direction = dir;
    rotation_event     = ev;
    next_cycle(n);
    rotation_event     = 1'b0;
  endtask

  // Push one event just after a slot edge; it is served at the next one.
  task automatic serve(input logic dir);
    apply_stimulus(1'b1, dir, 1);
    next_cycle(3);
  endtask

  task automatic press_center(input logic [1:0] from_mode, input logic [1:0] exp_mode,
                              input logic [7:0] exp_led);
    int lat;
    lat = 0;
    rot_center = 1'b1;
    do begin
      next_cycle(1);
      lat++;
    end while (mode == from_mode && lat < 40);
    check_output("adv_latency", 16'(lat), 16'd11);
    check_output("adv_mode", 16'(mode), 16'(exp_mode));
    check_output("adv_led", 16'(led), 16'(exp_led));
    check_output("adv_ovf", 16'(overflow), 16'd0);
    slot_pos   = 0;
    rot_center = 1'b0;
    next_cycle(12);
    check_output("release_no_adv", 16'(mode), 16'(exp_mode));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] ccw_exp [4];
    logic [7:0] bar_tab [9];
    logic [1:0] prev_mode;
    int adv_count, adv_k, lat;

    ccw_exp = '{8'h04, 8'h02, 8'h01, 8'h80};
    bar_tab = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    rst = 1'b1; rotation_event = 1'b0; rotation_direction = 1'b0; rot_center = 1'b0;
    ev_l = 1'b0; dir_l = 1'b0; center_l = 1'b0;
    next_cycle(3);
    rst = 1'b0;
    slot_pos = 0;
    $display("[TB] reset state");
    check_output("rst_led", 16'(led), 16'h01);
    check_output("rst_mode", 16'(mode), 16'd0);
    check_output("rst_ovf", 16'(overflow), 16'd0);
    check_output("rst_led_long", 16'(led_l), 16'h01);
    check_output("rst_mode_long", 16'(mode_l), 16'd0);

    $display("[TB] rotate CW burst");
    apply_stimulus(1'b1, 1'b1, 3);
    check_output("rot_not_early", 16'(led), 16'h01);
    next_cycle(1);
    check_output("rot_cw_1", 16'(led), 16'h02);
    next_cycle(3);
    check_output("rot_cw_hold", 16'(led), 16'h02);
    next_cycle(1);
    check_output("rot_cw_2", 16'(led), 16'h04);
    next_cycle(4);
    check_output("rot_cw_3", 16'(led), 16'h08);
    check_output("rot_ovf_clear", 16'(overflow), 16'd0);

    $display("[TB] rotate CCW");
    for (int i = 0; i < 4; i++) begin
      serve(1'b0);
      check_output("rot_ccw", 16'(led), 16'(ccw_exp[i]));
    end

    $display("[TB] bouncing center button, then overflow and mode advance");
    for (int i = 0; i < 30; i++) begin
      rot_center = ((i / 3) % 2 == 0);
      next_cycle(1);
    end
    check_output("bounce_ignored", 16'(mode), 16'd0);
    rot_center = 1'b1;
    prev_mode = 2'd0;
    adv_count = 0;
    adv_k = 0;
    for (int k = 1; k <= 20; k++) begin
      rotation_direction = 1'b1;
      rotation_event     = (k >= 4 && k <= 11);
      next_cycle(1);
      if (mode != prev_mode) begin
        adv_count++;
        if (adv_k == 0) adv_k = k;
        prev_mode = mode;
      end
      if (k == 10) begin
        check_output("ovf_set", 16'(overflow), 16'd1);
        check_output("rot_pre_adv", 16'(led), 16'h02);
      end
    end
    rotation_event = 1'b0;
    check_output("adv_once", 16'(adv_count), 16'd1);
    check_output("adv_cycle", 16'(adv_k), 16'd11);
    check_output("count_mode", 16'(mode), 16'd1);
    check_output("count_init_flushed", 16'(led), 16'h00);
    check_output("ovf_cleared", 16'(overflow), 16'd0);
    slot_pos = (20 - 11) % 4;
    rot_center = 1'b0;
    next_cycle(12);
    check_output("release_ignored", 16'(mode), 16'd1);
    while (slot_pos != 0) next_cycle(1);

    $display("[TB] count mode wrap");
    serve(1'b0);
    check_output("count_wrap_down", 16'(led), 16'hFF);
    serve(1'b1);
    check_output("count_wrap_up", 16'(led), 16'h00);
    serve(1'b1);
    check_output("count_inc", 16'(led), 16'h01);

    $display("[TB] bar mode");
    press_center(2'd1, 2'd2, 8'h00);
    for (int i = 0; i < 10; i++) begin
      serve(1'b1);
      check_output("bar_up", 16'(led), 16'(bar_tab[(i + 1 > 8) ? 8 : i + 1]));
    end
    for (int i = 0; i < 10; i++) begin
      serve(1'b0);
      check_output("bar_down", 16'(led), 16'(bar_tab[(i < 8) ? 7 - i : 0]));
    end

    $display("[TB] mode wrap and reset with queued events");
    press_center(2'd2, 2'd0, 8'h01);
    press_center(2'd0, 2'd1, 8'h00);
    apply_stimulus(1'b1, 1'b1, 6);
    check_output("pre_rst_ovf", 16'(overflow), 16'd1);
    check_output("pre_rst_led_a", 16'(led), 16'h01);
    next_cycle(2);
    check_output("pre_rst_led_b", 16'(led), 16'h02);
    rst = 1'b1;
    next_cycle(1);
    rst = 1'b0;
    slot_pos = 0;
    check_output("post_rst_led", 16'(led), 16'h01);
    check_output("post_rst_mode", 16'(mode), 16'd0);
    check_output("post_rst_ovf", 16'(overflow), 16'd0);
    next_cycle(12);
    check_output("post_rst_no_events", 16'(led), 16'h01);

    $display("[TB] long-slot instance fill and overflow");
    center_l = 1'b1;
    lat = 0;
    do begin
      next_cycle(1);
      lat++;
    end while (mode_l == 2'd0 && lat < 40);
    check_output("long_adv_latency", 16'(lat), 16'd11);
    check_output("long_mode", 16'(mode_l), 16'd1);
    check_output("long_led_init", 16'(led_l), 16'h00);
    dir_l = 1'b1;
    ev_l  = 1'b1;
    next_cycle(6);
    ev_l  = 1'b0;
    check_output("long_ovf", 16'(ov_l), 16'd1);
    check_output("long_not_served", 16'(led_l), 16'h00);
    next_cycle(10);
    check_output("long_inc_1", 16'(led_l), 16'h01);
    for (int i = 2; i <= 4; i++) begin
      next_cycle(16);
      check_output("long_inc", 16'(led_l), 16'(i));
    end
    next_cycle(32);
    check_output("long_dropped_absent", 16'(led_l), 16'h04);
    check_output("long_ovf_sticky", 16'(ov_l), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
